// File: rtl/gmii_tx_arb.sv
// rtl/gmii_tx_arb.sv - two-source GMII transmit arbiter with IFG and start timeout
// Optional GMII_ARB_RR_EN selects round-robin tie-break instead of fixed port-0 priority.
module gmii_tx_arb #(
    parameter int IFG_CYCLES = 12,
    parameter int START_TO   = 64
) (
    input  logic       gmii_txc,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       dv0,
    input  logic       dv1,
    input  logic [7:0] td0,
    input  logic [7:0] td1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       to_err,
    output logic       gmii_tx_dv,
    output logic [7:0] gmii_td
);

    localparam int IFG_EFF = (IFG_CYCLES < 1) ? 1 : IFG_CYCLES;
    localparam int MAX_P   = (IFG_EFF > START_TO) ? IFG_EFF : START_TO;
    localparam int CW      = $clog2(MAX_P) + 1;
    localparam logic [CW-1:0] TO_LAST  = CW'(START_TO - 1);
    localparam logic [CW-1:0] IFG_LAST = CW'(IFG_EFF - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          started_q, started_d;
    logic          to_err_q, to_err_d;
    logic          tx_dv_q, tx_dv_d;
    logic [7:0]    td_q, td_d;
    logic          tie_pref1;
    logic          pick1;
    logic          cur_req, cur_dv;
    logic          sel0, sel1;

`ifdef GMII_ARB_RR_EN
    // rr_q names the port preferred on the next tie; it flips away from every grant.
    logic rr_q, rr_d;
    assign tie_pref1 = rr_q;
`else
    assign tie_pref1 = 1'b0;
`endif

    assign pick1   = req1 & (~req0 | tie_pref1);
    assign cur_req = (state_q == BUSY1) ? req1 : req0;
    assign cur_dv  = (state_q == BUSY1) ? dv1 : dv0;
    assign sel0    = (state_q == BUSY0) & dv0;
    assign sel1    = (state_q == BUSY1) & dv1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        started_d = started_q;
        to_err_d  = 1'b0;
`ifdef GMII_ARB_RR_EN
        rr_d      = rr_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                started_d = 1'b0;
                if (req0 | req1) begin
                    state_d = pick1 ? BUSY1 : BUSY0;
`ifdef GMII_ARB_RR_EN
                    rr_d    = ~pick1;
`endif
                end
            end
            BUSY0, BUSY1: begin
                if (cur_dv) started_d = 1'b1;
                if (!cur_req) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (!started_q && !cur_dv && cnt_q == TO_LAST) begin
                    state_d  = GAP;
                    cnt_d    = '0;
                    to_err_d = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_dv_d = sel0 | sel1;
    assign td_d    = sel0 ? td0 : (sel1 ? td1 : 8'h00);

    always_ff @(posedge gmii_txc) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            started_q <= 1'b0;
            to_err_q  <= 1'b0;
            tx_dv_q   <= 1'b0;
            td_q      <= 8'h00;
`ifdef GMII_ARB_RR_EN
            rr_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            started_q <= started_d;
            to_err_q  <= to_err_d;
            tx_dv_q   <= tx_dv_d;
            td_q      <= td_d;
`ifdef GMII_ARB_RR_EN
            rr_q      <= rr_d;
`endif
        end
    end

    assign gnt0       = (state_q == BUSY0);
    assign gnt1       = (state_q == BUSY1);
    assign to_err     = to_err_q;
    assign gmii_tx_dv = tx_dv_q;
    assign gmii_td    = td_q;

endmodule

// File: tb/tb_gmii_tx_arb.sv
// tb/tb_gmii_tx_arb.sv - directed self-checking bench for gmii_tx_arb
module tb_gmii_tx_arb;

    localparam int IFG = 12;
    localparam int TO  = 64;

    logic       gmii_txc = 1'b0;
    logic       rst_n, req0, req1, dv0, dv1;
    logic [7:0] td0, td1;
    logic       gnt0, gnt1, to_err, gmii_tx_dv;
    logic [7:0] gmii_td;

    int         vecs = 0;
    int         fails = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_q[$];
    logic       exp_ord [3];

    gmii_tx_arb #(.IFG_CYCLES(IFG), .START_TO(TO)) dut (
        .gmii_txc   (gmii_txc),
        .rst_n      (rst_n),
        .req0       (req0),
        .req1       (req1),
        .dv0        (dv0),
        .dv1        (dv1),
        .td0        (td0),
        .td1        (td1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .to_err     (to_err),
        .gmii_tx_dv (gmii_tx_dv),
        .gmii_td    (gmii_td)
    );

    always #4 gmii_txc = ~gmii_txc;

    task automatic step();
        @(posedge gmii_txc);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every byte pushed at drive time must appear, in order, one cycle later.
    always @(negedge gmii_txc) begin
        if (mon_en) begin
            if (gmii_tx_dv === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vecs++;
                    fails++;
                    $error("FAIL stray_byte: observed %h expected none", gmii_td);
                end else begin
                    chk("byte", gmii_td, exp_q.pop_front());
                end
            end else begin
                chk("td_idle", gmii_td, 8'h00);
            end
        end
    end

    initial begin
        int  n;
        logic win;
`ifdef GMII_ARB_RR_EN
        exp_ord[0] = 1'b0; exp_ord[1] = 1'b1; exp_ord[2] = 1'b0;
`else
        exp_ord[0] = 1'b0; exp_ord[1] = 1'b0; exp_ord[2] = 1'b0;
`endif
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; dv0 = 1'b0; dv1 = 1'b0;
        td0 = 8'h00; td1 = 8'h00;
        step(); step();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_to_err", to_err, 0);
        chk("rst_dv", gmii_tx_dv, 0);
        chk("rst_td", gmii_td, 8'h00);
        mon_en = 1'b1;
        rst_n = 1'b1;
        step();

        // single 60-byte frame on port 1
        req1 = 1'b1;
        step();
        chk("t1_gnt1", gnt1, 1);
        chk("t1_gnt0", gnt0, 0);
        for (int i = 1; i <= 60; i++) begin
            dv1 = 1'b1; td1 = 8'(i); exp_q.push_back(8'(i));
            step();
            chk("t1_dv", gmii_tx_dv, 1);
        end
        dv1 = 1'b0; td1 = 8'h00; req1 = 1'b0;
        step();
        chk("t1_release", gnt1, 0);
        chk("t1_dv_end", gmii_tx_dv, 0);
        repeat (IFG + 2) step();

        // simultaneous requests; port 1 drives junk while port 0 owns the path
        req0 = 1'b1; req1 = 1'b1;
        step();
        chk("t2_gnt0", gnt0, 1);
        chk("t2_gnt1", gnt1, 0);
        for (int i = 0; i < 64; i++) begin
            dv0 = 1'b1; td0 = 8'(i + 8'h40); exp_q.push_back(8'(i + 8'h40));
            dv1 = 1'b1; td1 = 8'hEE;
            step();
        end
        dv0 = 1'b0; td0 = 8'h00; req0 = 1'b0; dv1 = 1'b0; td1 = 8'h00;
        step();
        chk("t2_release", gnt0, 0);
        n = 0;
        while (!gnt1 && n < 50) begin step(); n++; end
        chk("t2_gap", 8'(n), 8'(IFG + 1));
        for (int i = 0; i < 64; i++) begin
            dv1 = 1'b1; td1 = 8'(i + 8'hC0); exp_q.push_back(8'(i + 8'hC0));
            step();
        end
        dv1 = 1'b0; td1 = 8'h00; req1 = 1'b0;
        step();
        chk("t2_release1", gnt1, 0);
        repeat (IFG + 2) step();

        // three back-to-back tie rounds
        req0 = 1'b1; req1 = 1'b1;
        for (int r = 0; r < 3; r++) begin
            n = 0;
            while (!(gnt0 | gnt1) && n < 40) begin step(); n++; end
            chk("t3_granted", gnt0 | gnt1, 1);
            chk("t3_onehot", gnt0 & gnt1, 0);
            win = gnt1;
            chk("t3_order", win, exp_ord[r]);
            for (int i = 0; i < 4; i++) begin
                if (win) begin dv1 = 1'b1; td1 = 8'(8'h90 + r * 4 + i); end
                else     begin dv0 = 1'b1; td0 = 8'(8'h90 + r * 4 + i); end
                exp_q.push_back(8'(8'h90 + r * 4 + i));
                step();
            end
            dv0 = 1'b0; dv1 = 1'b0; td0 = 8'h00; td1 = 8'h00;
            if (r == 2) begin req0 = 1'b0; req1 = 1'b0; end
            else if (win) req1 = 1'b0;
            else req0 = 1'b0;
            step();
            chk("t3_release", gnt0 | gnt1, 0);
            req0 = (r < 2); req1 = (r < 2);
        end
        repeat (IFG + 2) step();

        // start timeout on port 0, then port 1 after the gap
        req0 = 1'b1;
        step();
        chk("t4_gnt0", gnt0, 1);
        repeat (TO - 1) step();
        chk("t4_hold", gnt0, 1);
        chk("t4_no_err", to_err, 0);
        step();
        chk("t4_revoke", gnt0, 0);
        chk("t4_to_err", to_err, 1);
        req0 = 1'b0; req1 = 1'b1;
        step();
        n = 1;
        chk("t4_err_pulse", to_err, 0);
        while (!gnt1 && n < 50) begin step(); n++; end
        chk("t4_gap", 8'(n), 8'(IFG + 1));
        req1 = 1'b0;
        step();
        repeat (IFG + 2) step();

        // reset in the middle of a port-1 frame
        req1 = 1'b1;
        step();
        chk("t5_gnt1", gnt1, 1);
        for (int i = 1; i < 20; i++) begin
            dv1 = 1'b1; td1 = 8'(i + 8'h20); exp_q.push_back(8'(i + 8'h20));
            step();
        end
        dv1 = 1'b1; td1 = 8'h34; rst_n = 1'b0;
        step();
        chk("t5_rst_gnt1", gnt1, 0);
        chk("t5_rst_gnt0", gnt0, 0);
        chk("t5_rst_dv", gmii_tx_dv, 0);
        chk("t5_rst_td", gmii_td, 8'h00);
        chk("t5_rst_err", to_err, 0);
        rst_n = 1'b1; dv1 = 1'b0; td1 = 8'h00;
        step();
        chk("t5_regrant", gnt1, 1);

        // port 0 drives while port 1 holds an idle grant
        dv0 = 1'b1; td0 = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_dv", gmii_tx_dv, 0);
            chk("t6_td", gmii_td, 8'h00);
        end
        dv0 = 1'b0; td0 = 8'h00; req1 = 1'b0;
        step();
        chk("t6_release", gnt1, 0);
        step();
        chk("q_empty", 8'(exp_q.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/gmii_tx_arb.md
# gmii_tx_arb

Two-requester arbiter that shares the single GMII transmit path in front of the GMII-to-RGMII DDR output stage between two frame sources (port 0: ARP/control, port 1: UDP payload). It grants the path to one source at a time with a level req/gnt handshake and registers the selected byte stream. It enforces a minimum inter-frame gap and recovers from a granted source that never starts its frame. Outputs feed `gmii_tx_dv` and `gmii_td` of the RGMII output stage directly.

## Interface
- `IFG_CYCLES`, default 12: idle `gmii_txc` cycles enforced between the release of one grant and the next grant.
- `START_TO`, default 64: maximum cycles from grant to first `dvN`=1 before the grant is revoked.
- `gmii_txc`, input, 1: 125 MHz transmit clock; the only clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `req0`, `req1`, input, 1 each: request; held high from request through the last byte of the frame.
- `dv0`, `dv1`, input, 1 each: per-source data valid.
- `td0`, `td1`, input, 8 each: per-source data byte.
- `gnt0`, `gnt1`, output, 1 each: grant; level, one-hot or zero.
- `to_err`, output, 1: one-cycle pulse when a start timeout revokes a grant.
- `gmii_tx_dv`, output, 1: registered muxed data valid.
- `gmii_td`, output, 8: registered muxed data byte.

## Operation
- States: IDLE, BUSY0, BUSY1, GAP.
- IDLE:
  - Any `reqN`=1 → BUSYN with `gntN`=1.
  - Both requesting: fixed priority to port 0 by default (see Configuration).
- BUSYN:
  - Started flag set on first `dvN`=1.
  - `reqN`=0 → GAP; `gntN` drops. Data seen in that same cycle is still forwarded.
  - Start timeout: not started and timeout counter reaches `START_TO`-1 → GAP. `gntN` drops and `to_err` pulses for 1 cycle.
  - `dvN` after the frame has started is not policed. Framing is the source's responsibility.
- GAP:
  - Counter loads 0 on entry and increments each cycle.
  - At `IFG_CYCLES`-1 → IDLE. No grant is issued while in GAP.
  - `IFG_CYCLES`=0 behaves as 1, i.e. a single GAP cycle.
- Datapath:
  - `gmii_tx_dv` ← (BUSY0 & `dv0`) | (BUSY1 & `dv1`).
  - `gmii_td` ← selected `tdN` when its dv=1, else 8'h00.
  - `dv` or `td` from a non-granted port never reaches the outputs.
- A `reqN` that drops before its grant is issued is lost with no side effects.
- Counters are `$clog2` of the larger parameter plus 1 bit wide and saturate; they never wrap.

## Timing
- Reset (`rst_n`=0 sampled at an edge): state IDLE; `gnt0`, `gnt1`, `to_err`, `gmii_tx_dv`=0; `gmii_td`=8'h00; counters 0; round-robin pointer → port 0. Reset mid-frame truncates the frame in the next cycle.
- Grant latency: `reqN` sampled high at edge k in IDLE → `gntN`=1 after edge k.
- Data latency: exactly 1 cycle from `dvN`/`tdN` to `gmii_tx_dv`/`gmii_td`.
- Release: `reqN` sampled low at edge k → `gntN`=0 after edge k.
- Earliest next grant: after edge k+`IFG_CYCLES`+1.
- Timeout: grant at edge g with no dv → `gntN`=0 and `to_err`=1 after edge g+`START_TO`.

## Configuration
- `GMII_ARB_RR_EN` defined: round-robin.
  - On simultaneous requests in IDLE, grant the port not served last.
  - The pointer updates on every grant, including grants later revoked by timeout.
- Undefined: fixed priority, port 0 always wins a tie. A sole requester is always granted regardless of mode.

## Test plan
- Single frame: `req1` high, `dv1` for 60 bytes 8'h01..8'h3C, then `req1` low. Expected: `gnt1` 1 cycle after req; `gmii_td` shows 01..3C 1 cycle delayed with `gmii_tx_dv` contiguous; `gnt1` drops 1 cycle after req falls.
- Tie, macro undefined: `req0` and `req1` rise together, each frame 64 bytes. Expected: port 0 first; `gnt1` exactly `IFG_CYCLES`+1 cycles after `gnt0` falls; no bytes from port 1 visible during BUSY0.
- Tie, `GMII_ARB_RR_EN` defined: back-to-back ties for three rounds. Expected: grant order 0, 1, 0.
- Start timeout: `req0` high, `dv0` never asserted, `START_TO`=64. Expected: `gnt0`=0 and `to_err`=1 for one cycle 64 cycles after grant; a later `req1` is granted after the gap.
- Reset mid-frame: `rst_n` low for 1 cycle at byte 20 of a port-1 frame. Expected: next cycle all outputs 0 and `gmii_td`=8'h00; a held `req1` is re-granted 1 cycle after `rst_n` returns high.
- Isolation: `dv0`=1 with `td0`=8'hAA while port 1 is granted and idle. Expected: `gmii_tx_dv` stays 0 and `gmii_td` stays 8'h00.
